head_table_mem: RTL and testbench
=================================

# head_table_mem

Storage stage for the hash table bucket-head array. It consumes the `head_table_if` write stream from the update engine and holds one head pointer plus a valid bit per bucket. It serves a registered read port to the lookup pipeline. After reset or on request, it sweeps every bucket to "empty" before accepting traffic.

## Interface

Parameters:
- `A_WIDTH`, default `BUCKET_WIDTH`: bucket address width; depth = 2^A_WIDTH.
- `D_WIDTH`, default `HEAD_PTR_WIDTH`: head pointer width.

Ports:
- `clk_i`  input  1  single clock for the whole block.
- `rst_i`  input  1  reset, asynchronous, active-high.
- `wr_if`  head_table_if.slave  bundle  write port: `wr_addr[A_WIDTH-1:0]`, `wr_data_ptr[D_WIDTH-1:0]`, `wr_data_ptr_val`, `wr_en`.
- `rd_addr_i`  input  A_WIDTH  read bucket address.
- `rd_en_i`  input  1  read request, one per cycle max.
- `rd_data_ptr_o`  output  D_WIDTH  head pointer read result.
- `rd_data_ptr_val_o`  output  1  head pointer valid bit of read result.
- `rd_val_o`  output  1  read result strobe, 1 cycle.
- `clear_i`  input  1  request full re-initialisation (pulse).
- `ready_o`  output  1  1 = init done, port traffic accepted.

## Operation

- FSM states: INIT and READY.
  - Reset places the FSM in INIT with `init_addr=0`.
- INIT:
  - Each clock writes {ptr=0, val=0} to `init_addr`, then increments `init_addr`.
  - The clock that writes address 2^A_WIDTH-1 transitions the FSM to READY.
  - `wr_en` and `rd_en_i` are ignored; writes are dropped and reads produce no `rd_val_o`.
  - `clear_i` is ignored; the sweep does not restart.
- READY:
  - `wr_en=1` writes {`wr_data_ptr`, `wr_data_ptr_val`} to `wr_addr`.
  - `rd_en_i=1` issues a read.
  - `clear_i=1`: the next state is INIT with `init_addr=0`.
    - A write in the same cycle is dropped (clear has priority).
    - A read in the same cycle is not issued.
    - Reads issued in earlier cycles complete normally with their already-captured data.
- Write with `wr_data_ptr_val=0` is a legal bucket invalidation. The pointer field is stored as given.
- Read coherency is write-first. A read issued at cycle T returns data including every write accepted at cycles ≤ T. This includes a write to the same address in cycle T itself. Writes at T+1 are not visible to that read.
- Address arithmetic:
  - `init_addr` is A_WIDTH bits and wraps to 0.
  - No out-of-range addresses exist.

## Timing

- Reset values (asynchronous):
  - `ready_o=0`, `rd_val_o=0`, `rd_data_ptr_o=0`, `rd_data_ptr_val_o=0`.
  - FSM=INIT, `init_addr=0`.
  - Memory contents are undefined until the sweep completes.
- Init duration: exactly 2^A_WIDTH rising edges after `rst_i` deasserts.
  - `ready_o` is registered and rises after the final sweep edge.
  - The first accepted write/read is on the edge 2^A_WIDTH+1.
- `ready_o` falls on the edge that samples `clear_i=1` in READY. It stays low for 2^A_WIDTH cycles.
- Read latency is 2 cycles: `rd_en_i` sampled at edge T gives `rd_val_o=1` with data valid after edge T+2.
  - Fully pipelined; back-to-back reads return back-to-back.
  - Read outputs hold their last value when `rd_val_o=0`.
- Write latency: the memory is updated at the sampling edge. Bypass covers the same-cycle read per the coherency rule.
- `rst_i` asserted mid-sweep or mid-read:
  - Immediately zeroes all outputs and flushes in-flight reads (no `rd_val_o`).
  - The sweep restarts from 0 on deassertion.

## Test plan

Configuration for all scenarios: A_WIDTH=4, D_WIDTH=8.

- Reset release -> `ready_o` rises after exactly 16 edges. Reads of all 16 addresses return `rd_data_ptr_val_o=0`, `rd_data_ptr_o=0x00`, each at +2 cycles.
- Write addr 3 ptr 0x5A val 1, then read addr 3 next cycle -> `rd_val_o` at +2 with `0x5A`/1. Back-to-back reads of addrs 3,4 -> results `0x5A`/1 then `0x00`/0 on consecutive cycles.
- Same-cycle write addr 7 ptr 0x33 val 1 with read addr 7 -> `0x33`/1 (write-first). A write addr 7 ptr 0x44 issued one cycle after the read -> that read still returns `0x33`.
- Write addr 2 ptr 0x11 val 1, then write addr 2 ptr 0x11 val 0 -> read returns `0x11`/0.
- `clear_i` pulsed with a concurrent write addr 5 ptr 0x77 -> `ready_o` low for 16 cycles. Writes and reads during the sweep are dropped, with no `rd_val_o`. Afterwards addr 5 reads val 0.
- `rst_i` asserted while `init_addr=9` -> outputs 0 immediately. After release, `ready_o` rises after a full 16 edges, not 7.

Source files
------------

// File: rtl/head_table_mem_if.sv
// head_table_if: write stream from the update engine into the bucket-head array.
// The update engine drives the master side and this storage stage is the slave.

interface head_table_if #(
   parameter int A_WIDTH = 10,
   parameter int D_WIDTH = 16
);
   logic [A_WIDTH-1:0] wr_addr;
   logic [D_WIDTH-1:0] wr_data_ptr;
   logic               wr_data_ptr_val;
   logic               wr_en;

   modport master (
      output wr_addr,
      output wr_data_ptr,
      output wr_data_ptr_val,
      output wr_en
   );

   modport slave (
      input wr_addr,
      input wr_data_ptr,
      input wr_data_ptr_val,
      input wr_en
   );
endinterface

// File: rtl/head_table_mem.sv
// head_table_mem: bucket-head storage for the hash table.
// Holds {head pointer, valid} per bucket, sweeps every bucket to empty after
// reset or on clear, and serves a 2-cycle, write-first registered read port.

package head_table_pkg;
   localparam int BUCKET_WIDTH   = 10;
   localparam int HEAD_PTR_WIDTH = 16;
endpackage

module head_table_mem
   import head_table_pkg::*;
#(
   parameter int A_WIDTH = BUCKET_WIDTH,
   parameter int D_WIDTH = HEAD_PTR_WIDTH
) (
   input  logic               clk_i,
   input  logic               rst_i,
   head_table_if.slave        wr_if,
   input  logic [A_WIDTH-1:0] rd_addr_i,
   input  logic               rd_en_i,
   output logic [D_WIDTH-1:0] rd_data_ptr_o,
   output logic               rd_data_ptr_val_o,
   output logic               rd_val_o,
   input  logic               clear_i,
   output logic               ready_o
);

   localparam int DEPTH  = 1 << A_WIDTH;
   // sample edge -> merge edge -> output edge
   localparam int STAGES = 3;

   typedef struct packed {
      logic [D_WIDTH-1:0] ptr;
      logic               val;
   } entry_t;

   typedef enum logic {
      INIT,
      READY
   } state_t;

   state_t             state;
   logic [A_WIDTH-1:0] init_addr;
   logic               ready;

   entry_t             mem [DEPTH];

   logic               wr_acc;
   logic               rd_acc;
   entry_t             wr_entry;

   logic               mem_we;
   logic [A_WIDTH-1:0] mem_waddr;
   entry_t             mem_wdata;

   // read pipeline
   logic [STAGES:1]    vld_pipe;
   entry_t             rd_q;        // raw memory word (pre-write value)
   logic               byp_q;       // same-cycle write hit the read address
   entry_t             byp_data_q;  // the data of that write
   entry_t             merge_q;     // write-first resolved word
   entry_t             out_q;

   assign wr_entry = '{ptr: wr_if.wr_data_ptr, val: wr_if.wr_data_ptr_val};

   // Port acceptance: only in READY, and clear pre-empts both ports
   always_comb begin
      wr_acc = 1'b0;
      rd_acc = 1'b0;
      if (state == READY && !clear_i) begin
         wr_acc = wr_if.wr_en;
         rd_acc = rd_en_i;
      end
   end

   // Single memory write port shared by the init sweep and the update stream
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_if.wr_addr;
      mem_wdata = wr_entry;
      if (state == INIT) begin
         mem_we    = 1'b1;
         mem_waddr = init_addr;
         mem_wdata = '0;
      end else if (wr_acc) begin
         mem_we    = 1'b1;
      end
   end

   // Init/ready FSM; ready_o is a registered copy of the state
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= INIT;
         init_addr <= '0;
         ready     <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               init_addr <= init_addr + 1'b1;
               if (&init_addr) begin
                  state <= READY;
                  ready <= 1'b1;
               end
            end
            READY: begin
               if (clear_i) begin
                  state     <= INIT;
                  init_addr <= '0;
                  ready     <= 1'b0;
               end
            end
            default: begin
               state     <= INIT;
               init_addr <= '0;
               ready     <= 1'b0;
            end
         endcase
      end
   end

   // Storage array with a synchronous read-old port; contents need no reset
   // because the sweep defines every word before traffic is accepted
   always_ff @(posedge clk_i) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
      if (rd_acc)
         rd_q <= mem[rd_addr_i];
   end

   // Capture a same-cycle write to the read address so the read sees it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         byp_q      <= 1'b0;
         byp_data_q <= '0;
      end else if (rd_acc) begin
         byp_q      <= wr_acc && (wr_if.wr_addr == rd_addr_i);
         byp_data_q <= wr_entry;
      end
   end

   // Valid shift register; reset flushes every in-flight read
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         vld_pipe <= '0;
      else
         vld_pipe <= {vld_pipe[STAGES-1:1], rd_acc};
   end

   // Resolve write-first, then present; outputs hold while no result is due
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         merge_q <= '0;
         out_q   <= '0;
      end else begin
         if (vld_pipe[1])
            merge_q <= byp_q ? byp_data_q : rd_q;
         if (vld_pipe[2])
            out_q <= merge_q;
      end
   end

   assign ready_o           = ready;
   assign rd_val_o          = vld_pipe[STAGES];
   assign rd_data_ptr_o     = out_q.ptr;
   assign rd_data_ptr_val_o = out_q.val;

endmodule

// File: tb/tb_head_table_mem.sv
// Directed bench for head_table_mem: a reference model of the bucket array and
// ready timing, with read expectations queued at issue and checked on return.

module tb_head_table_mem;
   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] rd_addr;
   logic          rd_en;
   logic          clear;
   logic [DW-1:0] rd_data_ptr;
   logic          rd_data_ptr_val;
   logic          rd_val;
   logic          ready;

   always #5 clk = ~clk;

   head_table_if #(.A_WIDTH(AW), .D_WIDTH(DW)) wr_if ();

   head_table_mem #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .wr_if             (wr_if),
      .rd_addr_i         (rd_addr),
      .rd_en_i           (rd_en),
      .rd_data_ptr_o     (rd_data_ptr),
      .rd_data_ptr_val_o (rd_data_ptr_val),
      .rd_val_o          (rd_val),
      .clear_i           (clear),
      .ready_o           (ready)
   );

   typedef struct {
      logic [DW-1:0] ptr;
      logic          val;
      int            due;
      string         tag;
   } exp_t;

   exp_t       sb[$];
   exp_t       got_e;
   logic [8:0] model [16];
   bit         ready_m;
   int         sweep_left;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Read-result monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rd_val === 1'b1) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL rd_val_unexpected got=1 exp=0 (nothing pending)");
         end
         if (sb.size() != 0) begin
            got_e = sb.pop_front();
            checks++;
            assert (rd_data_ptr === got_e.ptr) else begin
               errors++;
               $error("FAIL %s_ptr got=%02h exp=%02h", got_e.tag, rd_data_ptr, got_e.ptr);
            end
            checks++;
            assert (rd_data_ptr_val === got_e.val) else begin
               errors++;
               $error("FAIL %s_val got=%0b exp=%0b", got_e.tag, rd_data_ptr_val, got_e.val);
            end
            checks++;
            assert (cyc === got_e.due) else begin
               errors++;
               $error("FAIL %s_latency got_cycle=%0d exp_cycle=%0d", got_e.tag, cyc, got_e.due);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock of stimulus; updates the model and checks ready_o after the edge
   task automatic cycle(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wp,
                        input bit wv, input bit re, input logic [AW-1:0] ra,
                        input bit clr, input string tag);
      bit   was_ready;
      exp_t ne;
      was_ready             = ready_m;
      wr_if.wr_en           = we;
      wr_if.wr_addr         = wa;
      wr_if.wr_data_ptr     = wp;
      wr_if.wr_data_ptr_val = wv;
      rd_en                 = re;
      rd_addr               = ra;
      clear                 = clr;
      if (was_ready && !clr) begin
         if (we) model[wa] = {wp, wv};
         if (re) begin
            ne.ptr = model[ra][8:1];
            ne.val = model[ra][0];
            ne.due = cyc + 3;
            ne.tag = tag;
            sb.push_back(ne);
         end
      end
      tick();
      if (!was_ready) begin
         sweep_left--;
         if (sweep_left == 0) ready_m = 1'b1;
      end else if (clr) begin
         ready_m    = 1'b0;
         sweep_left = 16;
         for (int i = 0; i < 16; i++) model[i] = '0;
      end
      chk("ready", {31'd0, ready}, {31'd0, ready_m});
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(0, 0, 8'h00, 0, 0, 0, 0, "idle");
   endtask

   initial begin
      wr_if.wr_en = 0; wr_if.wr_addr = 0; wr_if.wr_data_ptr = 0; wr_if.wr_data_ptr_val = 0;
      rd_en = 0; rd_addr = 0; clear = 0;
      ready_m = 0; sweep_left = 16;
      for (int i = 0; i < 16; i++) model[i] = '0;

      // reset values
      #3;
      chk("rst_ready", {31'd0, ready}, 0);
      chk("rst_rd_val", {31'd0, rd_val}, 0);
      chk("rst_ptr", {24'd0, rd_data_ptr}, 0);
      chk("rst_ptr_val", {31'd0, rd_data_ptr_val}, 0);
      tick();
      rst = 0;

      // sweep: ready exactly after 16 edges
      idle(16);
      for (int a = 0; a < 16; a++) cycle(0, 0, 8'h00, 0, 1, AW'(a), 0, "init_rd");
      idle(3);

      // write then read; back-to-back reads
      cycle(1, 3, 8'h5A, 1, 0, 0, 0, "w3");
      cycle(0, 0, 8'h00, 0, 1, 3, 0, "rd3");
      cycle(0, 0, 8'h00, 0, 1, 3, 0, "rd3_b2b");
      cycle(0, 0, 8'h00, 0, 1, 4, 0, "rd4_b2b");
      idle(3);

      // write-first same cycle; a later write is not visible
      cycle(1, 7, 8'h33, 1, 1, 7, 0, "wf7");
      cycle(1, 7, 8'h44, 1, 0, 0, 0, "w7");
      idle(3);
      cycle(0, 0, 8'h00, 0, 1, 7, 0, "rd7_new");
      idle(3);

      // invalidation keeps the pointer
      cycle(1, 2, 8'h11, 1, 0, 0, 0, "w2");
      cycle(1, 2, 8'h11, 0, 0, 0, 0, "inv2");
      cycle(0, 0, 8'h00, 0, 1, 2, 0, "rd2_inv");
      idle(3);

      // clear with concurrent write and read; an earlier read completes
      cycle(1, 5, 8'h22, 1, 0, 0, 0, "w5");
      cycle(0, 0, 8'h00, 0, 1, 5, 0, "rd5_inflight");
      cycle(1, 5, 8'h77, 1, 1, 5, 1, "clr");
      for (int i = 0; i < 16; i++)
         cycle(1, AW'(i), 8'hAB, 1, 1, AW'(i), (i == 5), "sweep_drop");
      cycle(0, 0, 8'h00, 0, 1, 5, 0, "rd5_cleared");
      cycle(0, 0, 8'h00, 0, 1, 6, 0, "rd6_cleared");
      idle(3);

      // outputs hold while no result is due
      cycle(1, 9, 8'h9C, 1, 0, 0, 0, "w9");
      cycle(0, 0, 8'h00, 0, 1, 9, 0, "rd9");
      idle(5);
      chk("hold_ptr", {24'd0, rd_data_ptr}, 32'h9C);
      chk("hold_val", {31'd0, rd_data_ptr_val}, 1);

      // reset mid-sweep at init_addr=9
      cycle(0, 0, 8'h00, 0, 0, 0, 1, "clr2");
      idle(9);
      #2 rst = 1;
      #1;
      chk("midrst_ptr", {24'd0, rd_data_ptr}, 0);
      chk("midrst_val", {31'd0, rd_data_ptr_val}, 0);
      chk("midrst_ready", {31'd0, ready}, 0);
      ready_m = 0; sweep_left = 16;
      tick();
      rst = 0;
      idle(16);

      // reset flushes an in-flight read
      cycle(1, 9, 8'h5D, 1, 0, 0, 0, "w9b");
      cycle(0, 0, 8'h00, 0, 1, 9, 0, "rd9_flushed");
      rst = 1;
      sb.delete();
      #1;
      chk("flush_rd_val", {31'd0, rd_val}, 0);
      chk("flush_ptr", {24'd0, rd_data_ptr}, 0);
      ready_m = 0; sweep_left = 16;
      for (int i = 0; i < 16; i++) model[i] = '0;
      tick();
      rst = 0;
      idle(16);
      cycle(0, 0, 8'h00, 0, 1, 9, 0, "rd9_after_rst");
      idle(4);

      chk("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
